// File: rtl/draw_cmd_pkg.sv
// Command-word encoding and scheduler state shared between the draw-list
// scheduler and the Printer's command decoder.
package draw_cmd_pkg;

  localparam logic [31:0] CMD_HDR = 32'hFFFF_FFFF;
  localparam logic [31:0] CMD_EOF = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_HDR,
    ST_POS,
    ST_SPR,
    ST_EOF
  } sched_state_e;

  function automatic logic [31:0] pack_pos(input logic [15:0] x, input logic [15:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/obj_table.sv
// Flop-based object table: one write port, one asynchronous read port.
// Only the enables are reset; position/sprite contents are don't-care until enabled.
module obj_table #(
  parameter int NUM_OBJ = 16,
  parameter int IDX_W   = $clog2(NUM_OBJ),
  parameter int SPR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic             i_en,
  input  logic [15:0]      i_x,
  input  logic [15:0]      i_y,
  input  logic [SPR_W-1:0] i_spr,
  input  logic [IDX_W-1:0] i_ridx,
  output logic             o_en,
  output logic [15:0]      o_x,
  output logic [15:0]      o_y,
  output logic [SPR_W-1:0] o_spr
);

  logic [NUM_OBJ-1:0] r_en;
  logic [15:0]        r_x   [NUM_OBJ];
  logic [15:0]        r_y   [NUM_OBJ];
  logic [SPR_W-1:0]   r_spr [NUM_OBJ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en <= '0;
    end else if (i_we) begin
      r_en[i_widx] <= i_en;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_x[i_widx]   <= i_x;
      r_y[i_widx]   <= i_y;
      r_spr[i_widx] <= i_spr;
    end
  end

  // Read happens before the edge, so a same-cycle write is not yet visible.
  assign o_en  = r_en[i_ridx];
  assign o_x   = r_x[i_ridx];
  assign o_y   = r_y[i_ridx];
  assign o_spr = r_spr[i_ridx];

endmodule

// File: rtl/draw_list_scheduler.sv
// Per-frame walker over the object table: emits HDR/POS/SPR per enabled slot,
// then an optional EOF word, into the Printer's command FIFO.
module draw_list_scheduler
  import draw_cmd_pkg::*;
#(
  parameter int NUM_OBJ  = 16,
  parameter int IDX_W    = $clog2(NUM_OBJ),
  parameter int SPR_W    = 8,
  parameter bit EMIT_EOF = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [15:0]      cfg_x,
  input  logic [15:0]      cfg_y,
  input  logic [SPR_W-1:0] cfg_spr,
  input  logic             cmd_wfull,
  output logic             cmd_winc,
  output logic [31:0]      cmd_wdata,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(NUM_OBJ - 1);

  sched_state_e     r_state, w_state_next, w_done_state;
  logic [IDX_W:0]   r_idx, w_idx_next;
  logic [15:0]      r_x, r_y;
  logic [SPR_W-1:0] r_spr;
  logic             r_overrun;
  logic             w_snap_ld, w_last, w_push_state;
  logic             w_tab_en;
  logic [15:0]      w_tab_x, w_tab_y;
  logic [SPR_W-1:0] w_tab_spr;

  obj_table #(.NUM_OBJ(NUM_OBJ), .IDX_W(IDX_W), .SPR_W(SPR_W)) u_table (
    .clk    (clk),
    .rst    (rst),
    .i_we   (cfg_we),
    .i_widx (cfg_idx),
    .i_en   (cfg_en),
    .i_x    (cfg_x),
    .i_y    (cfg_y),
    .i_spr  (cfg_spr),
    .i_ridx (r_idx[IDX_W-1:0]),
    .o_en   (w_tab_en),
    .o_x    (w_tab_x),
    .o_y    (w_tab_y),
    .o_spr  (w_tab_spr)
  );

  assign w_last       = (r_idx == LAST_IDX);
  assign w_done_state = EMIT_EOF ? ST_EOF : ST_IDLE;
  assign w_push_state = (r_state == ST_HDR) || (r_state == ST_POS) ||
                        (r_state == ST_SPR) || (r_state == ST_EOF);
  assign busy         = (r_state != ST_IDLE);
  assign overrun      = r_overrun;

  always_comb begin
    cmd_winc  = w_push_state & ~cmd_wfull;
    cmd_wdata = 32'h0;
    case (r_state)
      ST_HDR:  cmd_wdata = CMD_HDR;
      ST_POS:  cmd_wdata = pack_pos(r_x, r_y);
      ST_SPR:  cmd_wdata = 32'(r_spr);
      ST_EOF:  cmd_wdata = CMD_EOF;
      default: cmd_wdata = 32'h0;
    endcase
  end

  // Push states advance only on an accepted write, which holds the word under back-pressure.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_snap_ld    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_state_next = ST_SCAN;
          w_idx_next   = '0;
        end
      end
      ST_SCAN: begin
        if (w_tab_en) begin
          w_state_next = ST_HDR;
          w_snap_ld    = 1'b1;
        end else begin
          w_idx_next = r_idx + 1'b1;
          if (w_last) w_state_next = w_done_state;
        end
      end
      ST_HDR: if (cmd_winc) w_state_next = ST_POS;
      ST_POS: if (cmd_winc) w_state_next = ST_SPR;
      ST_SPR: begin
        if (cmd_winc) begin
          w_idx_next   = r_idx + 1'b1;
          w_state_next = w_last ? w_done_state : ST_SCAN;
        end
      end
      ST_EOF:  if (cmd_winc) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_spr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (w_snap_ld) begin
        r_x   <= w_tab_x;
        r_y   <= w_tab_y;
        r_spr <= w_tab_spr;
      end
    end
  end

  // A set from a colliding frame_start takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (frame_start && busy) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

endmodule
